btb_update_queue: RTL and testbench
===================================

# btb_update_queue

Write-side companion of the branch target buffer. Collects resolved control-flow outcomes from the execute stage, buffers them in a small FIFO, and drains them into the BTB's write port one handshake at a time. It yields to BTB lookups so fetch-side reads are never stalled. Not-taken outcomes invalidate the matching entry; taken outcomes install or refresh the target.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- XLEN, 32, PC/target width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- upd_valid  in  1  EX stage presents a resolved branch/jal this cycle
- upd_pc  in  XLEN  PC of resolved instruction
- upd_target  in  XLEN  computed target (PC + imm)
- upd_taken  in  1  1 = install/refresh entry, 0 = invalidate entry
- upd_ready  out  1  queue can accept; enqueue iff upd_valid && upd_ready
- flush  in  1  drop all queued, not-in-flight updates
- btb_busy  in  1  BTB lookup in progress this cycle; blocks write issue
- btb_write  out  1  write request to BTB, held until btb_wresp
- btb_waddr  out  XLEN  PC being written
- btb_wdata  out  XLEN  target being written
- btb_wvalid  out  1  valid bit written with entry (= upd_taken)
- btb_wresp  in  1  BTB accepted write this cycle

## Operation
- Storage: DEPTH entries {pc, target, valid}; head/tail pointers wrap modulo DEPTH; count width clog2(DEPTH+1).
- upd_ready = (count != DEPTH); purely from registered count, so no enqueue when full even if a pop occurs same cycle.
- Coalescing: if an enqueue arrives, count ≥1, tail-1 entry pc == upd_pc and that entry is not in flight → overwrite that entry's target/valid in place, count unchanged. Otherwise allocate at tail.
- Drain FSM:
  - IDLE: if count ≠ 0 and !btb_busy and !flush → latch head into output regs, go WRITE.
  - WRITE: btb_write=1, btb_waddr/wdata/wvalid held stable. On btb_wresp → pop head, go IDLE. btb_busy is ignored once in WRITE (request already issued).
- Flush: entries not in flight cleared in the flush cycle (count set to 1 if WRITE active and head kept, else 0; tail = head + count). In-flight write completes normally; enqueue in the flush cycle is dropped.
- Simultaneous enqueue and pop (not full): both take effect; count unchanged.
- Reset mid-operation: all state cleared immediately, outstanding write abandoned; BTB side must tolerate a withdrawn request.

## Timing
- Reset values: btb_write=0, btb_waddr=0, btb_wdata=0, btb_wvalid=0, upd_ready=1, FSM=IDLE, count=0, head=tail=0.
- All outputs registered except upd_ready (decoded from registered count).
- Enqueue at edge N with empty queue and btb_busy low → btb_write high from cycle N+1 (after edge N+1 latches head; i.e. visible cycle N+2 at earliest counting edge N as cycle N).
- Precisely: IDLE samples count≠0 one cycle after enqueue edge; btb_write asserts the following cycle.
- Pop on edge where btb_wresp=1; btb_write low for at least one cycle between consecutive writes (max throughput 1 write / 2 cycles).
- btb_wresp while btb_write=0 is ignored.

## Structure
- Package btb_pkg: typedef btb_upd_t {pc, target, valid}; typedef enum drain state {IDLE, WRITE}.
- Sub-module btb_upd_fifo: DEPTH-entry circular buffer with enqueue, pop, tail-overwrite, flush-keep-head; top holds the drain FSM and output registers.

## Test plan
- Single taken update pc=0x60, target=0x80, btb_busy=0, wresp one cycle after request → one write {0x60,0x80,1}, count returns 0, upd_ready stays 1.
- Four updates back-to-back, btb_busy=1 throughout → upd_ready drops to 0 after 4th; fifth upd_valid ignored; release btb_busy → four writes in FIFO order.
- Two consecutive updates pc=0x100 (target 0x140 then not-taken) while busy → single write {0x100, x, 0}.
- Flush during WRITE of pc=0x20 with 3 queued → 0x20 write completes, no further writes, count=0 after wresp.
- Enqueue and wresp on same edge with count=2 → count stays 2, order preserved.
- Assert rst while btb_write=1 → btb_write=0 immediately (async), upd_ready=1, no writes after release.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types for the BTB write-side update queue: the buffered update record
// and the drain FSM encoding.
package btb_pkg;

    localparam int BTB_XLEN = 32;

    typedef struct packed {
        logic [BTB_XLEN-1:0] pc;
        logic [BTB_XLEN-1:0] target;
        logic                valid;
    } btb_upd_t;

    typedef enum logic [0:0] {
        DRAIN_IDLE  = 1'b0,
        DRAIN_WRITE = 1'b1
    } drain_state_e;

endpackage

// File: rtl/btb_update_queue_if.sv
// Bundle of the execute-side update handshake and the BTB write port.
// master = environment (EX stage + BTB), slave = the update queue.
interface btb_update_queue_if #(
    parameter int XLEN = 32
);
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic [XLEN-1:0] upd_target;
    logic            upd_taken;
    logic            upd_ready;
    logic            flush;
    logic            btb_busy;
    logic            btb_write;
    logic [XLEN-1:0] btb_waddr;
    logic [XLEN-1:0] btb_wdata;
    logic            btb_wvalid;
    logic            btb_wresp;

    modport master (
        output upd_valid, upd_pc, upd_target, upd_taken, flush, btb_busy, btb_wresp,
        input  upd_ready, btb_write, btb_waddr, btb_wdata, btb_wvalid
    );

    modport slave (
        input  upd_valid, upd_pc, upd_target, upd_taken, flush, btb_busy, btb_wresp,
        output upd_ready, btb_write, btb_waddr, btb_wdata, btb_wvalid
    );
endinterface

// File: rtl/btb_upd_fifo.sv
// Circular buffer of pending BTB updates with tail coalescing and a flush that
// can keep the in-flight head entry.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  logic [XLEN-1:0]  enq_pc,
    input  logic [XLEN-1:0]  enq_target,
    input  logic             enq_valid,
    input  logic             pop,
    input  logic             flush,
    input  logic             head_locked,
    input  logic             head_in_flight,
    output logic [CNT_W-1:0] count,
    output logic [XLEN-1:0]  head_pc,
    output logic [XLEN-1:0]  head_target,
    output logic             head_valid
);

    logic [XLEN-1:0]  pc_mem     [DEPTH];
    logic [XLEN-1:0]  target_mem [DEPTH];
    logic [DEPTH-1:0] valid_mem;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_prev;
    logic [PTR_W-1:0] wr_idx;
    logic             coalesce;
    logic             alloc;

    assign tail_prev = tail - PTR_W'(1);

    // A newer outcome for the youngest entry's PC replaces it, unless that entry
    // is the head already being (or about to be) handed to the BTB.
    assign coalesce = enq && (count != '0) && (pc_mem[tail_prev] == enq_pc)
                      && !((tail_prev == head) && head_locked);
    assign alloc    = enq && !coalesce;
    assign wr_idx   = coalesce ? tail_prev : tail;

    assign head_pc     = pc_mem[head];
    assign head_target = target_mem[head];
    assign head_valid  = valid_mem[head];

    always_ff @(posedge clk) begin
        if (enq) begin
            if (!coalesce) begin
                pc_mem[tail] <= enq_pc;
            end
            target_mem[wr_idx] <= enq_target;
            valid_mem[wr_idx]  <= enq_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            // Only the in-flight head survives a flush; if it completes in the
            // same cycle the queue ends up empty just past it.
            if (pop) begin
                head  <= head + PTR_W'(1);
                tail  <= head + PTR_W'(1);
                count <= '0;
            end else if (head_in_flight) begin
                tail  <= head + PTR_W'(1);
                count <= CNT_W'(1);
            end else begin
                tail  <= head;
                count <= '0;
            end
        end else begin
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (alloc) begin
                tail <= tail + PTR_W'(1);
            end
            count <= count + CNT_W'(alloc) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/btb_update_queue.sv
// Buffers resolved branch outcomes from EX and drains them into the BTB write
// port one handshake at a time, yielding to BTB lookups.
module btb_update_queue
    import btb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input logic               clk,
    input logic               rst,
    btb_update_queue_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [0:0] ST_IDLE  = DRAIN_IDLE;
    localparam logic [0:0] ST_WRITE = DRAIN_WRITE;

    logic [0:0]       state;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  head_pc;
    logic [XLEN-1:0]  head_target;
    logic             head_valid;
    logic             launch;
    logic             pop;
    logic             enq;
    logic             write_active;

    assign write_active  = (state == ST_WRITE);
    assign launch        = (state == ST_IDLE) && (count != '0) && !bus.btb_busy && !bus.flush;
    assign pop           = write_active && bus.btb_wresp;
    assign enq           = bus.upd_valid && bus.upd_ready && !bus.flush;
    assign bus.upd_ready = (count != CNT_W'(DEPTH));

    btb_upd_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .enq            (enq),
        .enq_pc         (bus.upd_pc),
        .enq_target     (bus.upd_target),
        .enq_valid      (bus.upd_taken),
        .pop            (pop),
        .flush          (bus.flush),
        .head_locked    (launch || write_active),
        .head_in_flight (write_active),
        .count          (count),
        .head_pc        (head_pc),
        .head_target    (head_target),
        .head_valid     (head_valid)
    );

    // Once a request is issued it is held until the BTB accepts it; lookups
    // only delay the launch of the next request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            bus.btb_write  <= 1'b0;
            bus.btb_waddr  <= '0;
            bus.btb_wdata  <= '0;
            bus.btb_wvalid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        bus.btb_write  <= 1'b1;
                        bus.btb_waddr  <= head_pc;
                        bus.btb_wdata  <= head_target;
                        bus.btb_wvalid <= head_valid;
                        state          <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (bus.btb_wresp) begin
                        bus.btb_write <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    bus.btb_write <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed self-checking bench for btb_update_queue (DEPTH=4, XLEN=32).
module tb_btb_update_queue;
    import btb_pkg::*;

    logic clk;
    logic rst;
    int   n_vectors;
    int   n_miscompares;

    btb_update_queue_if #(.XLEN(32)) bus ();

    btb_update_queue #(
        .DEPTH (4),
        .XLEN  (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_vectors++;
        assert (observed === expected)
        else begin
            n_miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] pc, input logic [31:0] target,
                                  input logic taken);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_target = target;
        bus.upd_taken  = taken;
        @(negedge clk);
        bus.upd_valid  = 1'b0;
    endtask

    task automatic wait_write(input string tag);
        int waited = 0;
        while (bus.btb_write !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_output({tag, "_req"}, 32'(bus.btb_write), 32'd1);
    endtask

    task automatic respond(input string tag, input logic [31:0] exp_pc,
                           input logic [31:0] exp_tgt, input logic exp_v);
        wait_write(tag);
        check_output({tag, "_addr"}, bus.btb_waddr, exp_pc);
        check_output({tag, "_data"}, bus.btb_wdata, exp_tgt);
        check_output({tag, "_valid"}, 32'(bus.btb_wvalid), 32'(exp_v));
        bus.btb_wresp = 1'b1;
        @(negedge clk);
        bus.btb_wresp = 1'b0;
        check_output({tag, "_gap"}, 32'(bus.btb_write), 32'd0);
    endtask

    task automatic idle_check(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            seen = seen | bus.btb_write;
        end
        check_output({tag, "_no_write"}, 32'(seen), 32'd0);
    endtask

    btb_upd_t exp_q [4];

    initial begin
        n_vectors      = 0;
        n_miscompares  = 0;
        clk            = 1'b0;
        rst            = 1'b1;
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_target = '0;
        bus.upd_taken  = 1'b0;
        bus.flush      = 1'b0;
        bus.btb_busy   = 1'b0;
        bus.btb_wresp  = 1'b0;

        #12;
        check_output("rst_write",  32'(bus.btb_write), 32'd0);
        check_output("rst_ready",  32'(bus.upd_ready), 32'd1);
        check_output("rst_waddr",  bus.btb_waddr, 32'd0);
        check_output("rst_wdata",  bus.btb_wdata, 32'd0);
        check_output("rst_wvalid", 32'(bus.btb_wvalid), 32'd0);
        check_output("rst_count",  32'(dut.u_fifo.count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] single taken update");
        apply_stimulus(32'h60, 32'h80, 1'b1);
        check_output("t1_lat_low", 32'(bus.btb_write), 32'd0);
        check_output("t1_count1",  32'(dut.u_fifo.count), 32'd1);
        @(negedge clk);
        check_output("t1_lat_high", 32'(bus.btb_write), 32'd1);
        respond("t1", 32'h60, 32'h80, 1'b1);
        check_output("t1_count0", 32'(dut.u_fifo.count), 32'd0);
        check_output("t1_ready",  32'(bus.upd_ready), 32'd1);

        $display("[TB] fill while busy, then drain in order");
        exp_q[0] = '{pc: 32'h200, target: 32'h1200, valid: 1'b1};
        exp_q[1] = '{pc: 32'h210, target: 32'h1210, valid: 1'b0};
        exp_q[2] = '{pc: 32'h220, target: 32'h1220, valid: 1'b1};
        exp_q[3] = '{pc: 32'h230, target: 32'h1230, valid: 1'b1};
        bus.btb_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(exp_q[i].pc, exp_q[i].target, exp_q[i].valid);
        end
        check_output("t2_full_ready", 32'(bus.upd_ready), 32'd0);
        check_output("t2_full_count", 32'(dut.u_fifo.count), 32'd4);
        check_output("t2_busy_write", 32'(bus.btb_write), 32'd0);
        apply_stimulus(32'h240, 32'h1240, 1'b1);
        check_output("t2_drop_count", 32'(dut.u_fifo.count), 32'd4);
        bus.btb_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            respond($sformatf("t2_w%0d", i), exp_q[i].pc, exp_q[i].target, exp_q[i].valid);
        end
        check_output("t2_count0", 32'(dut.u_fifo.count), 32'd0);
        idle_check("t2", 4);

        $display("[TB] coalesce same pc, stray wresp");
        bus.btb_busy = 1'b1;
        apply_stimulus(32'h100, 32'h140, 1'b1);
        apply_stimulus(32'h100, 32'h180, 1'b0);
        check_output("t3_count1", 32'(dut.u_fifo.count), 32'd1);
        bus.btb_wresp = 1'b1;
        @(negedge clk);
        bus.btb_wresp = 1'b0;
        check_output("t3_stray_count", 32'(dut.u_fifo.count), 32'd1);
        check_output("t3_stray_write", 32'(bus.btb_write), 32'd0);
        bus.btb_busy = 1'b0;
        respond("t3", 32'h100, 32'h180, 1'b0);
        idle_check("t3", 5);
        check_output("t3_count0", 32'(dut.u_fifo.count), 32'd0);

        $display("[TB] flush during write");
        bus.btb_busy = 1'b1;
        apply_stimulus(32'h20, 32'h1020, 1'b1);
        apply_stimulus(32'h24, 32'h1024, 1'b1);
        apply_stimulus(32'h28, 32'h1028, 1'b1);
        apply_stimulus(32'h2c, 32'h102c, 1'b1);
        bus.btb_busy = 1'b0;
        wait_write("t4_pre");
        check_output("t4_pre_count", 32'(dut.u_fifo.count), 32'd4);
        bus.flush      = 1'b1;
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h50;
        bus.upd_target = 32'h1050;
        bus.upd_taken  = 1'b1;
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.upd_valid = 1'b0;
        check_output("t4_flush_count", 32'(dut.u_fifo.count), 32'd1);
        check_output("t4_flush_addr",  bus.btb_waddr, 32'h20);
        respond("t4", 32'h20, 32'h1020, 1'b1);
        check_output("t4_count0", 32'(dut.u_fifo.count), 32'd0);
        idle_check("t4", 6);

        $display("[TB] enqueue and pop on the same edge");
        bus.btb_busy = 1'b1;
        apply_stimulus(32'h300, 32'h3300, 1'b1);
        apply_stimulus(32'h310, 32'h3310, 1'b1);
        bus.btb_busy = 1'b0;
        wait_write("t5_first");
        check_output("t5_first_addr", bus.btb_waddr, 32'h300);
        check_output("t5_pre_count", 32'(dut.u_fifo.count), 32'd2);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h320;
        bus.upd_target = 32'h3320;
        bus.upd_taken  = 1'b1;
        bus.btb_wresp  = 1'b1;
        @(negedge clk);
        bus.upd_valid  = 1'b0;
        bus.btb_wresp  = 1'b0;
        check_output("t5_same_count", 32'(dut.u_fifo.count), 32'd2);
        respond("t5_w1", 32'h310, 32'h3310, 1'b1);
        respond("t5_w2", 32'h320, 32'h3320, 1'b1);
        check_output("t5_count0", 32'(dut.u_fifo.count), 32'd0);

        $display("[TB] reset during write");
        bus.btb_busy = 1'b1;
        apply_stimulus(32'h400, 32'h4400, 1'b1);
        bus.btb_busy = 1'b0;
        wait_write("t6_pre");
        #2;
        rst = 1'b1;
        #1;
        check_output("t6_async_write", 32'(bus.btb_write), 32'd0);
        check_output("t6_async_ready", 32'(bus.upd_ready), 32'd1);
        check_output("t6_async_count", 32'(dut.u_fifo.count), 32'd0);
        check_output("t6_async_waddr", bus.btb_waddr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_check("t6", 5);
        check_output("t6_count0", 32'(dut.u_fifo.count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
